// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, a registered instruction slot held across decode stalls, and redirect/drop handling.
// Optional halt detection (opcode 4'hF) is compiled in with the HALT_DETECT_EN macro.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst_out,
    output logic        inst_valid,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [15:0] inst_out_q, inst_out_d;
    logic [15:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [15:0] redir_target;
    logic        halt_hit;

    // Instructions are halfword aligned, so bit 0 of a branch target is dropped.
    assign redir_target = redirect_pc & 16'hFFFE;

`ifdef HALT_DETECT_EN
    assign halt_hit = (inst_out_q[15:12] == 4'hF);
    assign halted   = (state_q == HALTED);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    assign imem_addr  = pc_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign pc_plus2   = inst_pc_q + 16'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ISSUE;
            pc_q         <= 16'h0000;
            drop_q       <= 1'b0;
            inst_out_q   <= 16'h0000;
            inst_pc_q    <= 16'h0000;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        imem_req     = 1'b0;
        case (state_q)
            ISSUE: begin
                if (redirect) begin
                    pc_d = redir_target;
                end else begin
                    imem_req = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = redir_target;
                    // The in-flight read still has to come back; remember to discard it.
                    if (imem_valid) begin
                        drop_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        inst_out_d   = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 16'd2;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = redir_target;
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end else if (!stall) begin
                    inst_valid_d = 1'b0;
                    state_d      = halt_hit ? HALTED : ISSUE;
                end
            end
            HALTED: begin
            end
            default: state_d = ISSUE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable memory model, scoreboard of expected captures,
// table of straight-line fetches plus directed redirect/reset/wrap/halt sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, imem_valid;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid, halted;
    logic [15:0] imem_addr, inst_out, inst_pc, pc_plus2;

    fetch_unit dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst_out(inst_out), .inst_valid(inst_valid), .inst_pc(inst_pc), .pc_plus2(pc_plus2),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] p2;
    } exp_t;

    typedef struct {
        int          lat;
        int          nstall;
        logic [15:0] pc;
        logic [15:0] next;
        logic [15:0] p2;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    bit          mem_en = 1'b1;
    logic [15:0] mem0   = 16'h1234;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        if (a == 16'h0000) return mem0;
        return {4'h3, a[11:0] ^ 12'h5A5};
    endfunction

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory: a request seen in cycle k returns data visible at the edge ending cycle k+lat.
    initial begin
        bit          pend = 1'b0;
        int          cnt  = 0;
        logic [15:0] paddr = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                if (mem_en) imem_valid = 1'b0;
            end else if (mem_en) begin
                imem_valid = 1'b0;
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_valid = 1'b1;
                        imem_rdata = mem_data(paddr);
                        pend       = 1'b0;
                    end
                end
                if (imem_req) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = imem_addr;
                end
            end
        end
    end

    // Scoreboard consumer: each newly presented instruction must match the oldest expectation.
    initial begin
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got inst %h pc %h want none", inst_out, inst_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk16("sb_inst", inst_out, e.inst);
                    chk16("sb_pc", inst_pc, e.pc);
                    chk16("sb_pc_plus2", pc_plus2, e.p2);
                end
            end
            prev_v = inst_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic wait_valid(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (inst_valid) begin
                got = 1'b1;
                break;
            end
            chk1({nm, "_one_outstanding"}, imem_req, 1'b0);
        end
        chk1({nm, "_valid_seen"}, got, 1'b1);
    endtask

    task automatic wait_req(input string nm, input logic [15:0] a);
        bit got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk1({nm, "_no_inst"}, inst_valid, 1'b0);
            if (imem_req) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        chk1({nm, "_req_seen"}, got, 1'b1);
        chk16({nm, "_addr"}, imem_addr, a);
    endtask

    task automatic run_vec(input vec_t v);
        lat = v.lat;
        sb.push_back('{mem_data(v.pc), v.pc, v.p2});
        stall = (v.nstall > 0);
        wait_valid("vec");
        for (int i = 1; i < v.nstall; i++) begin
            cyc();
            chk1("stall_valid", inst_valid, 1'b1);
            chk16("stall_inst", inst_out, mem_data(v.pc));
            chk16("stall_pc", inst_pc, v.pc);
            chk1("stall_no_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        cyc();
        chk1("consumed", inst_valid, 1'b0);
        chk1("next_req", imem_req, 1'b1);
        chk16("next_addr", imem_addr, v.next);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1, 0, 16'h0000, 16'h0002, 16'h0002};
        vecs[1] = '{1, 3, 16'h0002, 16'h0004, 16'h0004};
        vecs[2] = '{2, 1, 16'h0004, 16'h0006, 16'h0006};
        vecs[3] = '{3, 0, 16'h0006, 16'h0008, 16'h0008};
        vecs[4] = '{1, 2, 16'h0008, 16'h000A, 16'h000A};

        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; stall = 1'b0;
        imem_valid = 1'b0; imem_rdata = 16'h0000;
        cyc();
        cyc();
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk16("rst_inst_out", inst_out, 16'h0000);
        chk16("rst_inst_pc", inst_pc, 16'h0000);
        chk16("rst_pc_plus2", pc_plus2, 16'h0002);
        chk16("rst_imem_addr", imem_addr, 16'h0000);
        chk1("rst_halted", halted, 1'b0);
        rst = 1'b0;
        #1;
        chk1("first_req", imem_req, 1'b1);
        chk16("first_addr", imem_addr, 16'h0000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Redirect while WAIT; the read returns two cycles later and must be dropped.
        lat = 3;
        cyc();
        redirect = 1'b1; redirect_pc = 16'h0041;
        cyc();
        redirect = 1'b0;
        #1;
        wait_req("redir_wait", 16'h0040);
        run_vec('{1, 0, 16'h0040, 16'h0042, 16'h0042});

        // Redirect on the same cycle the data returns.
        lat = 1;
        cyc();
        redirect = 1'b1; redirect_pc = 16'h0080;
        cyc();
        redirect = 1'b0;
        #1;
        wait_req("redir_same", 16'h0080);
        run_vec('{1, 0, 16'h0080, 16'h0082, 16'h0082});

        // Back-to-back redirects: latest target wins.
        lat = 4;
        cyc();
        redirect = 1'b1; redirect_pc = 16'h0100;
        cyc();
        redirect_pc = 16'h0203;
        cyc();
        redirect = 1'b0;
        #1;
        wait_req("redir_rep", 16'h0202);
        run_vec('{1, 0, 16'h0202, 16'h0204, 16'h0204});

        // Redirect during a stalled HOLD kills the held instruction.
        lat = 1;
        sb.push_back('{mem_data(16'h0204), 16'h0204, 16'h0206});
        stall = 1'b1;
        wait_valid("hold_redir");
        redirect = 1'b1; redirect_pc = 16'h0300;
        cyc();
        redirect = 1'b0;
        #1;
        chk1("hold_redir_kill", inst_valid, 1'b0);
        stall = 1'b0;
        wait_req("hold_redir", 16'h0300);
        run_vec('{1, 0, 16'h0300, 16'h0302, 16'h0302});

        // Redirect in ISSUE suppresses the request, then wrap at FFFE.
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        #1;
        chk1("issue_redir_no_req", imem_req, 1'b0);
        cyc();
        redirect = 1'b0;
        #1;
        wait_req("wrap", 16'hFFFE);
        run_vec('{1, 0, 16'hFFFE, 16'h0000, 16'h0000});
        run_vec('{1, 0, 16'h0000, 16'h0002, 16'h0002});

        // Reset mid-WAIT; the abandoned read's data shows up after release and is ignored.
        lat = 4;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk1("midrst_inst_valid", inst_valid, 1'b0);
        chk16("midrst_inst_out", inst_out, 16'h0000);
        chk16("midrst_inst_pc", inst_pc, 16'h0000);
        chk16("midrst_imem_addr", imem_addr, 16'h0000);
        mem_en = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk1("midrst_req", imem_req, 1'b1);
        chk16("midrst_addr", imem_addr, 16'h0000);
        imem_valid = 1'b1; imem_rdata = 16'hDEAD;
        cyc();
        imem_valid = 1'b0;
        #1;
        chk1("stale_ignored", inst_valid, 1'b0);
        cyc();
        chk1("stale_ignored2", inst_valid, 1'b0);
        sb.push_back('{mem_data(16'h0000), 16'h0000, 16'h0002});
        imem_valid = 1'b1; imem_rdata = mem_data(16'h0000);
        cyc();
        imem_valid = 1'b0;
        chk1("midrst_capture", inst_valid, 1'b1);
        cyc();
        chk1("midrst_next_req", imem_req, 1'b1);
        chk16("midrst_next_addr", imem_addr, 16'h0002);
        mem_en = 1'b1;
        run_vec('{1, 0, 16'h0002, 16'h0004, 16'h0004});

        // Opcode 4'hF at address 0.
        rst = 1'b1;
        mem0 = 16'hF000;
        cyc();
        rst = 1'b0;
        lat = 1;
        #1;
        sb.push_back('{16'hF000, 16'h0000, 16'h0002});
        wait_valid("halt");
        cyc();
`ifdef HALT_DETECT_EN
        chk1("halt_flag", halted, 1'b1);
        chk1("halt_no_req", imem_req, 1'b0);
        redirect = 1'b1; redirect_pc = 16'h0010;
        #1;
        chk1("halt_redir_no_req", imem_req, 1'b0);
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("halt_stays", halted, 1'b1);
            chk1("halt_still_no_req", imem_req, 1'b0);
            chk16("halt_pc_kept", imem_addr, 16'h0002);
        end
`else
        chk1("nohalt_flag", halted, 1'b0);
        chk1("nohalt_req", imem_req, 1'b1);
        chk16("nohalt_addr", imem_addr, 16'h0002);
`endif

        cyc();
        cyc();
        chk16("sb_drained", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port redirect  in  1  branch taken, from the PC-control next_PC path; load redirect_pc.
REQ-004 SHALL have port redirect_pc  in  16  branch/BR target.
REQ-005 SHALL have port stall  in  1  decode cannot accept the presented instruction.
REQ-006 SHALL have port imem_req  out  1  one-cycle instruction-memory read strobe.
REQ-007 SHALL have port imem_addr  out  16  read address; equals pc.
REQ-008 SHALL have port imem_valid  in  1  read data valid, one or more cycles after imem_req.
REQ-009 SHALL have port imem_rdata  in  16  read data.
REQ-010 SHALL have port inst_out  out  16  registered instruction to decode.
REQ-011 SHALL have port inst_valid  out  1  inst_out holds an unconsumed instruction.
REQ-012 SHALL have port inst_pc  out  16  address of inst_out.
REQ-013 SHALL have port pc_plus2  out  16  inst_pc+2, the no-branch PC for PC control.
REQ-014 SHALL have port halted  out  1  fetch permanently stopped.

Function
REQ-015 SHALL implement states ISSUE, WAIT, HOLD, HALTED with one outstanding memory read at most.
REQ-016 ISSUE: imem_req = !redirect, imem_addr = pc; -> WAIT when request sent.
REQ-017 WAIT, imem_valid & !drop: inst_out<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+2; -> HOLD.
REQ-018 WAIT, imem_valid & drop: data discarded, drop<=0; -> ISSUE.
REQ-019 HOLD: instruction consumed on a cycle with inst_valid & !stall; then inst_valid<=0, -> ISSUE; stall holds all outputs stable.
REQ-020 redirect SHALL have highest priority in every state except HALTED: pc<=redirect_pc with bit 0 forced to 0.
REQ-021 redirect in ISSUE: no request issued that cycle; stay ISSUE.
REQ-022 redirect in WAIT without imem_valid: drop<=1, stay WAIT; with imem_valid same cycle: data discarded, -> ISSUE.
REQ-023 redirect in HOLD: inst_valid<=0 regardless of stall, -> ISSUE.
REQ-024 repeated redirects SHALL overwrite pc with the latest target; drop stays 1.
REQ-025 pc SHALL wrap modulo 2^16: 16'hFFFE+2 = 16'h0000; pc_plus2 wraps identically.
REQ-026 imem_valid outside WAIT SHALL be ignored.

Reset
REQ-027 rst SHALL asynchronously force pc=16'h0000, state=ISSUE, drop=0, inst_out=16'h0000, inst_pc=16'h0000, inst_valid=0, halted=0.
REQ-028 first imem_req SHALL occur in the first clk cycle after rst deasserts; reset during WAIT abandons the read and discards its late data.

Configuration
REQ-029 Macro HALT_DETECT_EN defined: instruction captured with opcode [15:12]=4'hF, once consumed, -> HALTED; HALTED issues no requests, ignores redirect, halted=1; exit only via rst.
REQ-030 Macro HALT_DETECT_EN undefined: opcode 4'hF fetched as a normal instruction; HALTED unreachable; halted tied 0.

Verification
REQ-031 Reset release, memory 1-cycle latency, mem[0]=16'h1234 -> imem_req@addr 0000, then inst_out=1234, inst_pc=0000, pc_plus2=0002, inst_valid=1.
REQ-032 stall=1 for 3 cycles in HOLD -> inst_out/inst_valid unchanged, no imem_req; stall=0 -> next request @0002.
REQ-033 redirect=1, redirect_pc=16'h0041 while WAIT, memory returns 2 cycles later -> returned data dropped, next imem_addr=0040, inst_valid never set for old data.
REQ-034 pc=16'hFFFE fetched -> inst_pc=FFFE, pc_plus2=0000, next imem_addr=0000.
REQ-035 HALT_DETECT_EN defined, mem[0]=16'hF000, consumed -> halted=1, no further imem_req, redirect to 0010 ignored; undefined -> next fetch @0002, halted=0.
REQ-036 rst asserted mid-WAIT with imem_valid arriving after release -> outputs at reset values, new request @0000, stale data not captured.
